// File: rtl/whack_round_controller.sv
// Whack-a-mole round sequencer: get-ready and play countdowns,
// mole gating, saturating score and round counting.
module whack_round_controller #(
    parameter int ROUND_SECS = 5,
    parameter int PRE_SECS   = 3,
    parameter int NUM_ROUNDS = 4,
    parameter int CNT_W      = 32,
    parameter int SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_1hz,
    input  logic               start,
    input  logic               hit,
    output logic [CNT_W-1:0]   countout,
    output logic [2:0]         state,
    output logic               mole_en,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         round,
    output logic               round_done,
    output logic               game_over
);

    if (ROUND_SECS < 1 || PRE_SECS < 1 ||
        NUM_ROUNDS < 1 || NUM_ROUNDS > 15) begin : g_bad_param
        $error("whack_round_controller: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_PLAY  = 3'd2,
        S_END   = 3'd3,
        S_OVER  = 3'd4
    } st_t;

    localparam logic [CNT_W-1:0]   PRE_CNT   = CNT_W'(PRE_SECS);
    localparam logic [CNT_W-1:0]   ROUND_CNT = CNT_W'(ROUND_SECS);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [3:0]         LAST_RND  = 4'(NUM_ROUNDS);

    st_t                st_q;
    st_t                st_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [SCORE_W-1:0] score_d;
    logic [3:0]         round_d;

    assign state = st_q;

    // Next state and next values of every registered output
    always_comb begin
        st_d    = st_q;
        cnt_d   = countout;
        score_d = score;
        round_d = round;
        case (st_q)
            S_IDLE: begin
                if (start) begin
                    st_d    = S_READY;
                    cnt_d   = PRE_CNT;
                    score_d = '0;
                    round_d = '0;
                end
            end
            S_READY: begin
                if (tick_1hz) begin
                    if (countout <= CNT_ONE) begin
                        st_d  = S_PLAY;
                        cnt_d = ROUND_CNT;
                    end else begin
                        cnt_d = countout - CNT_ONE;
                    end
                end
            end
            S_PLAY: begin
                if (hit && score != SCORE_MAX) begin
                    score_d = score + SCORE_ONE;
                end
                if (tick_1hz) begin
                    if (countout <= CNT_ONE) begin
                        st_d    = S_END;
                        cnt_d   = '0;
                        round_d = round + 4'd1;
                    end else begin
                        cnt_d = countout - CNT_ONE;
                    end
                end
            end
            S_END: begin
                if (round == LAST_RND) begin
                    st_d  = S_OVER;
                    cnt_d = '0;
                end else begin
                    st_d  = S_READY;
                    cnt_d = PRE_CNT;
                end
            end
            S_OVER: begin
                cnt_d = '0;
                if (start) begin
                    st_d    = S_READY;
                    cnt_d   = PRE_CNT;
                    score_d = '0;
                    round_d = '0;
                end
            end
            default: begin
                st_d  = S_IDLE;
                cnt_d = '0;
            end
        endcase
    end

    // Register state, counters and state-decoded flags together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q       <= S_IDLE;
            countout   <= '0;
            score      <= '0;
            round      <= '0;
            mole_en    <= 1'b0;
            round_done <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            st_q       <= st_d;
            countout   <= cnt_d;
            score      <= score_d;
            round      <= round_d;
            mole_en    <= (st_d == S_PLAY);
            round_done <= (st_d == S_END);
            game_over  <= (st_d == S_OVER);
        end
    end

endmodule
